// File: rtl/calc_alu_sequencer.sv
// Multi-cycle calculator ALU controller: single-cycle add/sub, shift-add multiply and
// restoring divide over WIDTH iterations, with a Done/Ack result handshake.
module calc_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Rem,
  output logic             Flag,
  output logic             Busy,
  output logic             Done,
  output logic             QI,
  output logic             QC,
  output logic             QD,
  output logic             QE
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_COMPUTE = 4'b0010,
    S_DONE    = 4'b0100,
    S_ERR     = 4'b1000
  } state_t;

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SUB   = 2'b01;
  localparam logic [1:0]       OP_MUL   = 2'b10;
  localparam logic [1:0]       OP_DIV   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   a_r, b_r, c_r, rem_r;
  logic [1:0]         op_r;
  logic               flag_r;
  logic [CNT_W-1:0]   cnt_r;
  // mul: {partial product, remaining multiplier}; div: {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_r;

  logic               last_s, div_zero_s;
  logic [WIDTH:0]     add_s, sub_s, mul_sum_s, div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s;

  // Arithmetic for the current compute step
  always_comb begin
    last_s      = (cnt_r == CNT_LAST);
    div_zero_s  = (Op == OP_DIV) && (B == {WIDTH{1'b0}});
    add_s       = {1'b0, a_r} + {1'b0, b_r};
    sub_s       = {1'b0, a_r} - {1'b0, b_r};
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, a_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, b_r};
    // A borrow means the trial subtraction failed: restore and shift in a 0
    if (div_trial_s[WIDTH]) begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_s = div_zero_s ? S_ERR : S_COMPUTE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (!op_r[1] || last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_COMPUTE;
        end
      end
      S_DONE, S_ERR: begin
        if (Ack) begin
          state_s = S_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= 2'b00;
      cnt_r  <= {CNT_W{1'b0}};
      acc_r  <= {(2*WIDTH){1'b0}};
      c_r    <= {WIDTH{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
      flag_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= Op;
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= (Op == OP_DIV) ? {{WIDTH{1'b0}}, A} : {{WIDTH{1'b0}}, B};
            if (div_zero_s) begin
              c_r    <= {WIDTH{1'b1}};
              rem_r  <= {WIDTH{1'b0}};
              flag_r <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (!last_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          case (op_r)
            OP_ADD: begin
              c_r    <= add_s[WIDTH-1:0];
              rem_r  <= {WIDTH{1'b0}};
              flag_r <= add_s[WIDTH];
            end
            OP_SUB: begin
              c_r    <= sub_s[WIDTH-1:0];
              rem_r  <= {WIDTH{1'b0}};
              flag_r <= sub_s[WIDTH];
            end
            OP_MUL: begin
              acc_r <= mul_next_s;
              if (last_s) begin
                c_r    <= mul_next_s[WIDTH-1:0];
                rem_r  <= {WIDTH{1'b0}};
                flag_r <= |mul_next_s[2*WIDTH-1:WIDTH];
              end
            end
            default: begin
              acc_r <= div_next_s;
              if (last_s) begin
                c_r    <= div_next_s[WIDTH-1:0];
                rem_r  <= div_next_s[2*WIDTH-1:WIDTH];
                flag_r <= 1'b0;
              end
            end
          endcase
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign C    = c_r;
  assign Rem  = rem_r;
  assign Flag = flag_r;
  assign QI   = (state_r == S_IDLE);
  assign QC   = (state_r == S_COMPUTE);
  assign QD   = (state_r == S_DONE);
  assign QE   = (state_r == S_ERR);
  assign Busy = QC;
  assign Done = QD | QE;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Self-checking bench for calc_alu_sequencer: directed plan cases, protocol corner
// cases and randomized operations against an arithmetic reference model.
module tb_calc_alu_sequencer;

  logic        board_clk = 1'b0;
  logic        Reset, Start, Ack;
  logic [15:0] A, B, C, Rem;
  logic [1:0]  Op;
  logic        Flag, Busy, Done, QI, QC, QD, QE;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 board_clk = ~board_clk;

  calc_alu_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .board_clk(board_clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .A(A), .B(B), .Op(Op), .C(C), .Rem(Rem), .Flag(Flag),
    .Busy(Busy), .Done(Done), .QI(QI), .QC(QC), .QD(QD), .QE(QE)
  );

  // Reference: result, remainder, flag and number of Busy cycles (0 = error path)
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       output logic [15:0] c, output logic [15:0] r, output logic f,
                       output int lat);
    logic [31:0] p;
    logic [16:0] s;
    r = 16'd0;
    case (op)
      2'd0: begin s = a + b; c = s[15:0]; f = s[16]; lat = 1; end
      2'd1: begin c = a - b; f = (a < b); lat = 1; end
      2'd2: begin p = a * b; c = p[15:0]; f = (p[31:16] != 16'd0); lat = 16; end
      default: begin
        if (b == 16'd0) begin c = 16'hFFFF; f = 1'b1; lat = 0; end
        else begin c = a / b; r = a % b; f = 1'b0; lat = 16; end
      end
    endcase
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    @(negedge board_clk);
    A = a; B = b; Op = op; Start = 1'b1;
    @(negedge board_clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int busy, output bit to);
    busy = 0;
    for (int i = 0; i < 100 && !Done; i++) begin
      if (Busy) busy++;
      @(negedge board_clk);
    end
    to = !Done;
  endtask

  task automatic ack_op();
    Ack = 1'b1;
    @(negedge board_clk);
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({QI, QC, QD, QE, Busy, Done, Flag, C, Rem} !== {4'b1000, 3'b000, 16'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected QI only, zero outputs",
               {QI, QC, QD, QE, Busy, Done, Flag, C, Rem});
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [7];
    logic [15:0] tb [7];
    logic [1:0]  to_p [7];
    logic [15:0] ec, er;
    logic        ef;
    int          lat, busy;
    bit          to;
    ta   = '{16'hFFFF, 16'd5, 16'd7, 16'd12, 16'h0100, 16'd100, 16'd5};
    tb   = '{16'h0001, 16'd7, 16'd5, 16'd13, 16'h0100, 16'd7,   16'd0};
    to_p = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 7; i++) begin
      model(ta[i], tb[i], to_p[i], ec, er, ef, lat);
      issue(ta[i], tb[i], to_p[i]);
      wait_done(busy, to);
      n_cmp++;
      if (to || busy != lat) begin
        n_bad++;
        $display("FAIL dir_latency[%0d]: got %0d busy cycles (timeout=%0d) expected %0d", i, busy, to, lat);
      end
      n_cmp++;
      if ({C, Rem, Flag} !== {ec, er, ef}) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got C=%h Rem=%h Flag=%b expected C=%h Rem=%h Flag=%b",
                 i, C, Rem, Flag, ec, er, ef);
      end
      n_cmp++;
      if ({QD, QE} !== ((lat == 0) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL dir_state[%0d]: got QD=%b QE=%b expected error=%0d", i, QD, QE, lat == 0);
      end
      ack_op();
      n_cmp++;
      if (QI !== 1'b1 || Done !== 1'b0 || C !== ec || Flag !== ef) begin
        n_bad++;
        $display("FAIL dir_after_ack[%0d]: got QI=%b Done=%b C=%h expected QI=1 Done=0 C=%h", i, QI, Done, C, ec);
      end
    end
  endtask

  task automatic test_compute_ignore();
    int busy;
    bit to;
    issue(16'd12, 16'd13, 2'd2);
    repeat (3) begin
      A = 16'hFFFF; B = 16'hFFFF; Op = 2'd3; Start = 1'b1; Ack = 1'b1;
      @(negedge board_clk);
    end
    Start = 1'b0; Ack = 1'b0;
    wait_done(busy, to);
    n_cmp++;
    if (to || busy != 13 || C !== 16'd156 || Flag !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_in_compute: got busy=%0d C=%0d Flag=%b expected busy=13 C=156 Flag=0", busy, C, Flag);
    end
    // Start together with Ack in DONE: Ack wins, nothing new is started
    A = 16'd1; B = 16'd1; Op = 2'd0; Start = 1'b1; Ack = 1'b1;
    @(negedge board_clk);
    Start = 1'b0; Ack = 1'b0;
    n_cmp++;
    if (QI !== 1'b1 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ack_done: got QI=%b Busy=%b expected QI=1 Busy=0", QI, Busy);
    end
    @(negedge board_clk);
    n_cmp++;
    if (QI !== 1'b1 || C !== 16'd156) begin
      n_bad++;
      $display("FAIL start_ack_idle: got QI=%b C=%0d expected QI=1 C=156", QI, C);
    end
  endtask

  task automatic test_reset_mid();
    int busy;
    bit to;
    issue(16'd100, 16'd7, 2'd3);
    repeat (7) @(negedge board_clk);
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({QI, Busy, Done, Flag, C, Rem} !== {4'b1000, 16'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_div: got QI=%b Busy=%b Done=%b Flag=%b C=%h Rem=%h expected QI=1 rest 0",
               QI, Busy, Done, Flag, C, Rem);
    end
    #1 Reset = 1'b0;
    issue(16'd100, 16'd7, 2'd3);
    wait_done(busy, to);
    n_cmp++;
    if (to || busy != 16 || C !== 16'd14 || Rem !== 16'd2 || Flag !== 1'b0) begin
      n_bad++;
      $display("FAIL div_after_reset: got busy=%0d C=%0d Rem=%0d Flag=%b expected 16 14 2 0", busy, C, Rem, Flag);
    end
    ack_op();
  endtask

  task automatic test_random();
    logic [15:0] a, b, ec, er;
    logic [1:0]  op;
    logic        ef;
    int          lat, busy;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (op == 2'd2 && $urandom_range(0, 1) == 0) begin
        a = a >> $urandom_range(8, 15);
        b = b >> $urandom_range(8, 15);
      end
      if (op == 2'd3 && $urandom_range(0, 4) == 0) b = 16'd0;
      model(a, b, op, ec, er, ef, lat);
      issue(a, b, op);
      A = 16'($urandom); B = 16'($urandom); Op = 2'($urandom_range(0, 3));
      wait_done(busy, to);
      n_cmp++;
      if (to || busy != lat || {C, Rem, Flag} !== {ec, er, ef}) begin
        n_bad++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got busy=%0d C=%h Rem=%h Flag=%b expected busy=%0d C=%h Rem=%h Flag=%b",
                 i, op, a, b, busy, C, Rem, Flag, lat, ec, er, ef);
      end
      ack_op();
      n_cmp++;
      if (QI !== 1'b1 || C !== ec) begin
        n_bad++;
        $display("FAIL rand_ack[%0d]: got QI=%b C=%h expected QI=1 C=%h", i, QI, C, ec);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    A = 16'd0; B = 16'd0; Op = 2'd0;
    repeat (2) @(negedge board_clk);
    test_reset();
    Reset = 1'b0;
    Ack = 1'b1;
    @(negedge board_clk);
    Ack = 1'b0;
    n_cmp++;
    if (QI !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_in_idle: got QI=%b expected 1", QI);
    end
    test_directed();
    test_compute_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
